psg_multitone: RTL and testbench
================================

# psg_multitone

Parametrised programmable sound generator for the Spectrum audio path, succeeding the fixed six-channel SAA-style generator. It provides NCH square-tone channels with a shared 17-bit noise source and per-channel stereo volume, and a time-multiplexed mixer that produces saturated OUT_W-bit stereo samples. It sits on the CPU I/O write bus and feeds the audio DAC/sigma-delta stage.

## Interface
- NCH, 6: channel count, 1..60.
- FW, 12: tone divider width, 9..16.
- OUT_W, 12: output sample width.
- GAIN_SHIFT, 5: left shift applied to the channel sum before saturation.
- clk_sys  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low; clock clk_sys.
- ce  in  1  tone-rate clock enable, one clk_sys wide; period must be ≥ NCH+2 clocks.
- wr  in  1  register write strobe, one clock wide.
- addr  in  8  register address.
- din  in  8  write data.
- out_l, out_r  out  OUT_W  left and right samples.
- sample_valid  out  1  one-clock pulse when out_l/out_r update.

## Operation
- Register map, channel c, base 4c:
  - +0: freq[7:0].
  - +1: freq[FW-1:8] in the low bits.
  - +2: vol, R in [7:4], L in [3:0].
  - +3: tone_en in [0], noise_en in [1].
- Global registers:
  - 0xF0: noise_rate in [1:0].
  - 0xFF: ctrl, sound_en in [0], soft_rst in [1].
- Writes to unmapped addresses are ignored.
- Tone channel: down-counter clocked by ce.
  - At 0: reload with freq and toggle the tone bit. Half-period is freq+1 ce ticks; freq=0 toggles every ce.
  - A freq write does not touch the running count. It takes effect at the next reload (glitch-free).
- Noise: LFSR next = {l[0]^l[3], l[16:1]}; noise bit = l[0].
  - noise_rate 0..2: LFSR steps every 256<<noise_rate ce ticks.
  - noise_rate 3: LFSR steps on each channel-0 tone toggle.
- Channel active bit:
  - tone_en&noise_en: tone&noise.
  - tone_en only: tone.
  - noise_en only: noise.
  - neither: 0.
- Mixer FSM, states IDLE → SWEEP → LATCH → IDLE:
  - IDLE: on ce, snapshot all NCH active bits, clear both accumulators, go to SWEEP.
  - SWEEP: one channel per clock, index 0..NCH-1. Add volL/volR when the snapshot bit is set.
  - LATCH: out = min(sum<<GAIN_SHIFT, 2^OUT_W−1), or 0 if sound_en=0. Pulse sample_valid.
  - ce arriving outside IDLE starts no new sweep. Tone and noise counters still advance.
- Accumulators are 4+clog2(NCH+1) bits. They never wrap.
- soft_rst=1 holds all tone counters at freq, tone bits at 0, the LFSR at seed and the noise prescaler at 0. Registers keep their values. The mixer keeps running, so outputs settle to 0.

## Timing
- Reset (rst_n=0 at a clk_sys edge):
  - All registers, tone bits and counters = 0; LFSR = 17'h00001.
  - FSM = IDLE; out_l = out_r = 0; sample_valid = 0.
  - Reset mid-sweep aborts the sweep; no sample_valid is produced.
- A register write is visible on the clock after the wr cycle. A write on the same cycle as ce uses the old value for that ce.
- Sample latency: ce at cycle T → sample_valid and the new outputs at T+NCH+2. Outputs hold between pulses.
- A channel toggling during a sweep does not affect that sweep, because the snapshot is taken at T.

## Structure
- Package psg_pkg:
  - register offsets (0xF0, 0xFF, per-channel +0..+3);
  - LFSR seed and tap constants;
  - mixer FSM state enum;
  - a clog2 helper for accumulator width.
- Sub-module psg_tone_chan (FW-bit divider, reload-at-zero, tone bit, toggle pulse), generated NCH times.
- The noise generator, mixer FSM and register file stay in the top module.

## Test plan
- Reset, then idle ce pulses → out_l=out_r=0 and sample_valid every ce at T+NCH+2.
- ch0 freq=3, tone_en=1, vol=0xF5, sound_en=1 → tone toggles every 4 ce ticks. High samples read out_l=0xA0, out_r=0x1E0; low samples read 0/0.
- All 6 channels vol=0xFF, forced high, GAIN_SHIFT=8 → out_l=out_r=0xFFF (saturated).
- freq rewritten mid-period from 100 to 2 → the current half-period still completes at 101 ticks; later half-periods are 3 ticks.
- noise_rate=3, ch0 freq=0 → the LFSR steps once per ce. The first 4 noise bits after the seed are 1,0,0,0.
- soft_rst=1 mid-tone → the tone bit drops to 0 and the next samples are 0. soft_rst=0 → the tone restarts from a full freq+1 half-period.

Source files
------------

// File: rtl/psg_pkg.sv
// Shared constants, mixer state encoding and sizing helper for the
// multi-channel programmable sound generator.
package psg_pkg;

  localparam logic [7:0] ADDR_NOISE = 8'hF0;
  localparam logic [7:0] ADDR_CTRL  = 8'hFF;

  localparam logic [1:0] OFF_FREQ_LO = 2'd0;
  localparam logic [1:0] OFF_FREQ_HI = 2'd1;
  localparam logic [1:0] OFF_VOL     = 2'd2;
  localparam logic [1:0] OFF_EN      = 2'd3;

  localparam logic [16:0] LFSR_SEED = 17'h00001;
  localparam int unsigned LFSR_TAP  = 3;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    LATCH
  } mix_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/psg_tone_chan.sv
// Square-tone divider: counts ce ticks down from freq, toggles the tone bit
// and reloads at zero, so a half-period is freq+1 ticks.
module psg_tone_chan #(
  parameter int unsigned FW = 12
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          hold,
  input  logic [FW-1:0] freq,
  output logic          tone,
  output logic          toggle
);

  logic [FW-1:0] cnt;

  // freq is only sampled at reload, so rewriting it never truncates a half-period
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (hold) begin
      cnt  <= freq;
      tone <= 1'b0;
    end else if (ce) begin
      if (cnt == '0) begin
        cnt  <= freq;
        tone <= ~tone;
      end else begin
        cnt <= cnt - FW'(1);
      end
    end
  end

  assign toggle = ce && !hold && (cnt == '0);

endmodule

// File: rtl/psg_multitone.sv
// NCH-channel square/noise sound generator with register file, shared LFSR
// noise source and a time-multiplexed saturating stereo mixer.
module psg_multitone
  import psg_pkg::*;
#(
  parameter int unsigned NCH        = 6,
  parameter int unsigned FW         = 12,
  parameter int unsigned OUT_W      = 12,
  parameter int unsigned GAIN_SHIFT = 5
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             wr,
  input  logic [7:0]       addr,
  input  logic [7:0]       din,
  output logic [OUT_W-1:0] out_l,
  output logic [OUT_W-1:0] out_r,
  output logic             sample_valid
);

  localparam int unsigned ACC_W = 4 + clog2(NCH + 1);
  localparam int unsigned IDX_W = (NCH > 1) ? clog2(NCH) : 1;
  localparam int unsigned WIDE  = ACC_W + GAIN_SHIFT + OUT_W;
  localparam logic [WIDE-1:0]  OUT_MAX      = WIDE'({OUT_W{1'b1}});
  localparam logic [NCH-1:0]   NOISE_CLK_CH = NCH'(1);

  logic [FW-1:0]  freq_r [NCH];
  logic [7:0]     vol_r  [NCH];
  logic [NCH-1:0] ten_r, nen_r;
  logic [1:0]     noise_rate;
  logic           sound_en, soft_rst;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        freq_r[c] <= '0;
        vol_r[c]  <= '0;
      end
      ten_r      <= '0;
      nen_r      <= '0;
      noise_rate <= '0;
      sound_en   <= 1'b0;
      soft_rst   <= 1'b0;
    end else if (wr) begin
      if (addr == ADDR_NOISE) noise_rate <= din[1:0];
      if (addr == ADDR_CTRL) begin
        sound_en <= din[0];
        soft_rst <= din[1];
      end
      for (int unsigned c = 0; c < NCH; c++) begin
        if (addr[7:2] == 6'(c)) begin
          case (addr[1:0])
            OFF_FREQ_LO: freq_r[c][7:0]    <= din;
            OFF_FREQ_HI: freq_r[c][FW-1:8] <= din[FW-9:0];
            OFF_VOL:     vol_r[c]          <= din;
            OFF_EN: begin
              ten_r[c] <= din[0];
              nen_r[c] <= din[1];
            end
            default: ;
          endcase
        end
      end
    end
  end

  logic [NCH-1:0] tone, toggle;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    psg_tone_chan #(.FW(FW)) u_chan (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .ce      (ce),
      .hold    (soft_rst),
      .freq    (freq_r[g]),
      .tone    (tone[g]),
      .toggle  (toggle[g])
    );
  end

  logic [16:0] lfsr;
  logic [10:0] presc, presc_lim;
  logic        noise_step;

  always_comb begin
    presc_lim  = (11'd256 << noise_rate) - 11'd1;
    noise_step = (noise_rate == 2'd3) ? |(toggle & NOISE_CLK_CH)
                                      : (ce && presc >= presc_lim);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n || soft_rst) begin
      lfsr  <= LFSR_SEED;
      presc <= '0;
    end else begin
      if (ce && noise_rate != 2'd3)
        presc <= (presc >= presc_lim) ? '0 : presc + 11'd1;
      if (noise_step)
        lfsr <= {lfsr[0] ^ lfsr[LFSR_TAP], lfsr[16:1]};
    end
  end

  logic [NCH-1:0] active;

  always_comb begin
    active = '0;
    for (int unsigned c = 0; c < NCH; c++)
      active[c] = (ten_r[c] | nen_r[c]) & (~ten_r[c] | tone[c]) & (~nen_r[c] | lfsr[0]);
  end

  function automatic logic [OUT_W-1:0] sat(input logic [ACC_W-1:0] a);
    logic [WIDE-1:0] w;
    w = WIDE'(a) << GAIN_SHIFT;
    return (w > OUT_MAX) ? '1 : w[OUT_W-1:0];
  endfunction

  mix_state_t     state, state_nx;
  logic [NCH-1:0] snap;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc_l, acc_r;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ce) state_nx = SWEEP;
      SWEEP:   if (idx == IDX_W'(NCH - 1)) state_nx = LATCH;
      LATCH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      snap         <= '0;
      idx          <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      out_l        <= '0;
      out_r        <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: if (ce) begin
          snap  <= active;
          idx   <= '0;
          acc_l <= '0;
          acc_r <= '0;
        end
        SWEEP: begin
          if (snap[idx]) begin
            acc_l <= acc_l + ACC_W'(vol_r[idx][3:0]);
            acc_r <= acc_r + ACC_W'(vol_r[idx][7:4]);
          end
          idx <= idx + IDX_W'(1);
        end
        LATCH: begin
          out_l        <= sound_en ? sat(acc_l) : '0;
          out_r        <= sound_en ? sat(acc_r) : '0;
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psg_multitone.sv
// Directed bench for psg_multitone: default instance plus a GAIN_SHIFT=8
// instance sharing the same bus, for the saturation case.
module tb_psg_multitone;

  localparam int unsigned NCH = 6;
  localparam int unsigned LAT = NCH + 2;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        ce      = 1'b0;
  logic        wr      = 1'b0;
  logic [7:0]  addr    = '0;
  logic [7:0]  din     = '0;
  logic [11:0] out_l, out_r, out_l8, out_r8;
  logic        sample_valid, sample_valid8;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;
  int unsigned lat;
  logic [11:0] s_l, s_r, s_l8, s_r8;
  logic        seen;
  logic        hi;

  psg_multitone #(.NCH(NCH), .FW(12), .OUT_W(12), .GAIN_SHIFT(5)) dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .ce           (ce),
    .wr           (wr),
    .addr         (addr),
    .din          (din),
    .out_l        (out_l),
    .out_r        (out_r),
    .sample_valid (sample_valid)
  );

  psg_multitone #(.NCH(NCH), .FW(12), .OUT_W(12), .GAIN_SHIFT(8)) dut8 (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .ce           (ce),
    .wr           (wr),
    .addr         (addr),
    .din          (din),
    .out_l        (out_l8),
    .out_r        (out_r8),
    .sample_valid (sample_valid8)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; din = d;
    cyc(1);
    wr = 1'b0;
    cyc(1);
  endtask

  task automatic soft_pulse();
    wr_reg(8'hFF, 8'h03);
    wr_reg(8'hFF, 8'h01);
  endtask

  // One ce pulse; waits (bounded) for sample_valid and captures all outputs.
  task automatic do_ce();
    ce  = 1'b1;
    lat = 0;
    s_l = 'x; s_r = 'x; s_l8 = 'x; s_r8 = 'x;
    for (int unsigned n = 1; n <= 20 && lat == 0; n++) begin
      cyc(1);
      ce = 1'b0;
      if (sample_valid) begin
        lat  = n;
        s_l  = out_l;
        s_r  = out_r;
        s_l8 = out_l8;
        s_r8 = out_r8;
      end
    end
    cyc(1);
  endtask

  task automatic chk_tone(input string tag, input logic high);
    check({tag, "_l"}, 32'(s_l), high ? 32'h0A0 : 32'h0);
    check({tag, "_r"}, 32'(s_r), high ? 32'h1E0 : 32'h0);
  endtask

  initial begin
    cyc(3);
    check("rst_out_l", 32'(out_l), 32'h0);
    check("rst_out_r", 32'(out_r), 32'h0);
    check("rst_sv", 32'(sample_valid), 32'h0);
    rst_n = 1'b1;
    cyc(1);

    for (int k = 0; k < 2; k++) begin
      do_ce();
      check($sformatf("idle_lat%0d", k), lat, LAT);
      check($sformatf("idle_l%0d", k), 32'(s_l), 32'h0);
      check($sformatf("idle_r%0d", k), 32'(s_r), 32'h0);
    end

    // reset during a sweep must not produce a sample
    ce = 1'b1;
    cyc(1);
    ce = 1'b0;
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      cyc(1);
      if (sample_valid) seen = 1'b1;
    end
    check("rst_abort_sv", 32'(seen), 32'h0);

    // ch0: freq=3, tone only, vol L=5 R=15
    wr_reg(8'h00, 8'h03);
    wr_reg(8'h01, 8'h00);
    wr_reg(8'h02, 8'hF5);
    wr_reg(8'h03, 8'h01);
    soft_pulse();
    for (int k = 1; k <= 12; k++) begin
      do_ce();
      if (k == 1) check("tone_lat", lat, LAT);
      chk_tone($sformatf("tone%0d", k), (k >= 5 && k <= 8));
    end
    do_ce();
    chk_tone("tone13", 1'b1);

    wr_reg(8'hFF, 8'h03);
    do_ce();
    chk_tone("softrst_hold", 1'b0);
    wr_reg(8'hFF, 8'h01);
    for (int k = 1; k <= 5; k++) begin
      do_ce();
      chk_tone($sformatf("restart%0d", k), (k == 5));
    end

    wr_reg(8'hFF, 8'h00);
    do_ce();
    chk_tone("sound_off", 1'b0);
    wr_reg(8'hFF, 8'h01);
    do_ce();
    chk_tone("sound_on", 1'b1);

    // freq 100 rewritten to 2 after 10 ticks: first toggle still at tick 101
    wr_reg(8'h00, 8'h64);
    soft_pulse();
    for (int k = 1; k <= 110; k++) begin
      if (k == 11) wr_reg(8'h00, 8'h02);
      do_ce();
      hi = (k >= 102 && k <= 104) || (k >= 108);
      check($sformatf("freq_l%0d", k), 32'(s_l), hi ? 32'h0A0 : 32'h0);
    end

    // all channels noise-only, full volume, noise bit = seed bit 1
    for (int c = 0; c < 6; c++) begin
      wr_reg(8'(4 * c + 2), 8'hFF);
      wr_reg(8'(4 * c + 3), 8'h02);
    end
    soft_pulse();
    do_ce();
    check("sum_l_g5", 32'(s_l), 32'hB40);
    check("sum_r_g5", 32'(s_r), 32'hB40);
    check("sat_l_g8", 32'(s_l8), 32'hFFF);
    check("sat_r_g8", 32'(s_r8), 32'hFFF);

    // noise_rate 3 with ch0 freq 0: one LFSR step per ce
    for (int c = 1; c < 6; c++) wr_reg(8'(4 * c + 3), 8'h00);
    wr_reg(8'h00, 8'h00);
    wr_reg(8'h02, 8'hF5);
    wr_reg(8'hF0, 8'h03);
    soft_pulse();
    for (int k = 1; k <= 4; k++) begin
      do_ce();
      chk_tone($sformatf("noise%0d", k), (k == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
